// File: rtl/spi_pkg.sv
// spi_pkg - shared FSM encoding and defaults for the spi_slave responder.
// Rev 1.0
`default_nettype none

package spi_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_DONE  = 2'd2
  } spis_state_e;

  localparam logic [7:0] FILL_BYTE_DEFAULT = 8'hFF;

endpackage

`default_nettype wire

// File: rtl/spi_sync.sv
// spi_sync - SYNC_STAGES-deep flop chain with clock enable and async active-low reset.
// Rev 1.0
`default_nettype none

module spi_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic clock_valid,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q <= {SYNC_STAGES{RESET_VALUE}};
    end else if (clock_valid) begin
      for (int i = SYNC_STAGES - 1; i > 0; i--) begin
        sync_q[i] <= sync_q[i-1];
      end
      sync_q[0] <= d_i;
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/spi_slave.sv
// spi_slave - SPI mode-3 responder with a 4-phase command/response handshake.
// Rev 1.0. Optional sticky overrun flag: define SPI_SLAVE_OVERRUN_EN.
`default_nettype none

module spi_slave
  import spi_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] FILL_BYTE   = FILL_BYTE_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clock_valid,
  input  logic       sck,
  input  logic       ss,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  input  logic       spis_command,
  input  logic [7:0] spis_send_data,
  output logic       spis_response,
  output logic [7:0] spis_receive_data
`ifdef SPI_SLAVE_OVERRUN_EN
  ,
  output logic       spis_overrun
`endif
);

  logic sck_s, ss_s, mosi_s;

  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b1)) u_sync_sck (
    .clock(clock), .reset(reset), .clock_valid(clock_valid), .d_i(sck), .q_o(sck_s)
  );
  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b1)) u_sync_ss (
    .clock(clock), .reset(reset), .clock_valid(clock_valid), .d_i(ss), .q_o(ss_s)
  );
  spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VALUE(1'b0)) u_sync_mosi (
    .clock(clock), .reset(reset), .clock_valid(clock_valid), .d_i(mosi), .q_o(mosi_s)
  );

  spis_state_e state_q, state_d;
  logic        sck_prev_q, ss_prev_q;
  logic [7:0]  tx_hold_q, tx_hold_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  rx_q, rx_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        armed_q, armed_d;
  logic        seen_rise_q, seen_rise_d;
  logic        miso_q, miso_d;

  logic        sck_rise, sck_fall, ss_fall, ss_rise, byte_done;
  logic        reload_armed;
  logic [7:0]  reload_byte, shifted;

  always_comb begin
    sck_rise  = sck_s & ~sck_prev_q;
    sck_fall  = ~sck_s & sck_prev_q;
    ss_fall   = ~ss_s & ss_prev_q;
    ss_rise   = ss_s & ~ss_prev_q;
    shifted   = {shift_q[6:0], mosi_s};
    byte_done = sck_rise & ~ss_s & ~ss_fall & (cnt_q == 3'd7);
    // A byte completing its armed handshake leaves S_ARMED, so the next byte must not reuse tx_hold.
    reload_armed = (state_q == S_ARMED) && !(byte_done && armed_q);
    reload_byte  = reload_armed ? tx_hold_q : FILL_BYTE;
  end

  always_comb begin
    state_d     = state_q;
    tx_hold_d   = tx_hold_q;
    shift_d     = shift_q;
    rx_d        = rx_q;
    cnt_d       = cnt_q;
    armed_d     = armed_q;
    seen_rise_d = seen_rise_q;
    miso_d      = miso_q;

    unique case (state_q)
      S_IDLE: begin
        if (spis_command) begin
          state_d   = S_ARMED;
          tx_hold_d = spis_send_data;
        end
      end
      S_ARMED: if (byte_done && armed_q) state_d = S_DONE;
      S_DONE:  if (!spis_command) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (ss_fall) begin
      cnt_d       = 3'd0;
      shift_d     = reload_byte;
      armed_d     = reload_armed;
      miso_d      = reload_byte[7];
      seen_rise_d = 1'b0;
    end else if (ss_rise) begin
      cnt_d       = 3'd0;
      armed_d     = 1'b0;
      seen_rise_d = 1'b0;
    end else if (!ss_s) begin
      if (sck_rise) begin
        if (cnt_q == 3'd7) begin
          if (armed_q) rx_d = shifted;
          cnt_d       = 3'd0;
          shift_d     = reload_byte;
          armed_d     = reload_armed;
          miso_d      = reload_byte[7];
          seen_rise_d = 1'b0;
        end else begin
          shift_d     = shifted;
          cnt_d       = cnt_q + 3'd1;
          seen_rise_d = 1'b1;
        end
      end else if (sck_fall && seen_rise_q) begin
        miso_d = shift_q[7];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      sck_prev_q  <= 1'b1;
      ss_prev_q   <= 1'b1;
      tx_hold_q   <= 8'h00;
      shift_q     <= 8'h00;
      rx_q        <= 8'h00;
      cnt_q       <= 3'd0;
      armed_q     <= 1'b0;
      seen_rise_q <= 1'b0;
      miso_q      <= 1'b1;
    end else if (clock_valid) begin
      state_q     <= state_d;
      sck_prev_q  <= sck_s;
      ss_prev_q   <= ss_s;
      tx_hold_q   <= tx_hold_d;
      shift_q     <= shift_d;
      rx_q        <= rx_d;
      cnt_q       <= cnt_d;
      armed_q     <= armed_d;
      seen_rise_q <= seen_rise_d;
      miso_q      <= miso_d;
    end
  end

  assign miso              = miso_q;
  assign miso_oe           = ~ss_s;
  assign spis_response     = (state_q == S_DONE);
  assign spis_receive_data = rx_q;

`ifdef SPI_SLAVE_OVERRUN_EN
  logic overrun_q, overrun_d;

  always_comb begin
    overrun_d = overrun_q | (byte_done & (~armed_q | (state_q == S_DONE)));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overrun_q <= 1'b0;
    end else if (clock_valid) begin
      overrun_q <= overrun_d;
    end
  end

  assign spis_overrun = overrun_q;
`endif

endmodule

`default_nettype wire

// File: doc/spi_slave.md
# spi_slave

SPI responder peripheral for the E100 I/O bus. It is the other end of the `spi_master`/`spi` pair: the E100 stages one byte to send, and an external SPI master clocks a frame. The block returns the byte the master sent over a 4-phase `spis_command`/`spis_response` handshake. It uses SPI mode 3 (SCK idles high, both lines sampled on the rising edge, MSB first), which matches `spi_master`.

## Interface
- `SYNC_STAGES`, default 2: synchronizer depth applied to `sck`, `ss` and `mosi`.
- `FILL_BYTE`, default 8'hFF: byte shifted out when no E100 data is armed.
- `clock` input 1: system clock.
- `reset` input 1: asynchronous, active-low reset.
- `clock_valid` input 1: clock enable. No state advances while it is low.
- `sck` input 1: SPI clock from the external master, asynchronous.
- `ss` input 1: slave select, active low, asynchronous.
- `mosi` input 1: serial data from the master.
- `miso` output 1: serial data to the master.
- `miso_oe` output 1: MISO output enable, high while the synchronized `ss` is low.
- `spis_command` input 1: E100 request. High means "arm `spis_send_data` and wait for one frame".
- `spis_send_data` input 8: byte to transmit. Sampled in the cycle the command is accepted.
- `spis_response` output 1: high when `spis_receive_data` holds the byte from the armed frame.
- `spis_receive_data` output 8: last byte received in an armed frame.
- `spis_overrun` output 1: sticky flag. Present only when the overrun feature is compiled in (see Configuration).

## Operation
- **Synchronization and edge detect.** `sck`, `ss` and `mosi` pass through `SYNC_STAGES` flops each. A rising or falling SCK edge is detected by comparing the last synchronized sample with the previous one. The frame start event is a falling edge of the synchronized `ss`.
- **Handshake FSM states:** `S_IDLE`, `S_ARMED`, `S_DONE`.
  - `S_IDLE`: when `spis_command` is 1, latch `spis_send_data` into `tx_hold` and go to `S_ARMED`.
  - `S_ARMED`: stay here until a frame that began while armed completes.
  - `S_DONE`: `spis_response` is 1 in this state. Go to `S_IDLE` when `spis_command` is 0.
- **Frame start.**
  - Clear the 3-bit bit counter.
  - Load the shift register from `tx_hold` if the FSM is in `S_ARMED`; otherwise load it from `FILL_BYTE`.
  - Record `frame_armed` (whether the frame started in `S_ARMED`).
  - `miso` presents bit 7 immediately.
- **Rising SCK edge while `ss` is low.**
  - Shift the synchronized `mosi` in at the LSB.
  - Increment the bit counter.
- **Falling SCK edge while `ss` is low.** Update `miso` to the new MSB, but only after at least one rising edge has occurred in the current byte.
- **Byte completion (8th rising edge).**
  - If `frame_armed`: `spis_receive_data` takes the shifted byte and the FSM goes to `S_DONE`.
  - Otherwise the byte is discarded.
  - After completion the counter wraps to 0 and the shift register reloads as at frame start, so several bytes can be sent under one `ss`. A follow-on byte is armed only if the FSM is in `S_ARMED`.
- **Boundary conditions.**
  - `ss` rising mid-byte: abort the byte. Counter goes to 0, no data is transferred, and the FSM state is unchanged (an armed request stays armed).
  - Command raised mid-frame: the request arms, but the current frame still shifts the fill byte. The next frame completes the handshake.
  - Completion and command drop in the same cycle: FSM goes `S_ARMED`→`S_DONE`, then returns to `S_IDLE` on the next enabled cycle.
  - `clock_valid` low: all registers hold, and edges occurring then may be missed. The system must keep `clock_valid` high during SPI activity.
  - `reset` asserted mid-frame: immediate return to reset values, and the frame is lost.

## Timing
- **Reset values:** `miso` 1, `miso_oe` 0, `spis_response` 0, `spis_receive_data` 8'h00, `spis_overrun` 0, FSM `S_IDLE`, counter 0.
- **Input latency:** an external pin change is seen internally `SYNC_STAGES`+1 clocks later.
- **SCK limit:** each SCK half-period must be at least `SYNC_STAGES`+2 clocks. `spi_master` with `CLK_DIV`=10 satisfies this easily.
- **MISO setup:** `miso` changes `SYNC_STAGES`+1 clocks after a falling SCK edge and is stable before the next rising edge.
- **Response latency:** `spis_response` rises 1 clock after the internal detection of the 8th rising edge.
- **Response hold:** `spis_response` falls 1 clock after `spis_command` is sampled low.
- **Command hold:** `spis_command` must stay high until `spis_response` is seen high.

## Configuration
- `SPI_SLAVE_OVERRUN_EN` defined: the `spis_overrun` port exists.
  - It sets to 1 when a byte completes in an unarmed frame, or in any frame while in `S_DONE`.
  - It clears only on reset.
- Macro undefined: the port and its logic are absent, and unarmed bytes are silently dropped.

## Structure
- `spi_pkg`: holds the FSM state encoding (2 bits, `S_IDLE`=0, `S_ARMED`=1, `S_DONE`=2) and the default `FILL_BYTE` constant.
- Sub-module `spi_sync`: a parameterized `SYNC_STAGES` synchronizer with `clock_valid` enable and asynchronous active-low reset. It is instantiated three times (reset value 1 for `sck` and `ss`, 0 for `mosi`).

## Test plan
- **Armed single frame:** command with send 8'hA5; master sends 8'h3C → master reads 8'hA5, `spis_receive_data`=8'h3C, response high; response drops 1 clock after command is low.
- **Unarmed frame:** master sends 8'h55 with no command → master reads 8'hFF, response stays 0, overrun=1 (macro on).
- **Abort:** arm 8'h81; `ss` rises after 4 bits; then a full frame with 8'h0F → first frame produces no response; second returns 8'h0F and master reads 8'h81.
- **Command mid-frame:** command raised during bit 3 → that frame shifts 8'hFF with no response; the next frame completes the handshake.
- **Two bytes under one `ss`:** arm 8'h12; master sends 8'hAA then 8'hBB → response with 8'hAA; second byte sees 8'hFF and is dropped (overrun=1).
- **Reset:** `reset` low mid-frame → all outputs return to reset values asynchronously, and the next armed frame completes normally.
